clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the divide ratio.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, divide ratio loaded at reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port div_in  input  WIDTH  requested divide ratio N.
REQ-006 SHALL have port div_load  input  1  one-cycle request to capture div_in.
REQ-007 SHALL have port div_ack  output  1  one-cycle pulse when a new ratio takes effect.
REQ-008 SHALL have port div_active  output  WIDTH  ratio currently in use.
REQ-009 SHALL have port clk_out  output  1  divided clock, registered.
REQ-010 SHALL have port clk_en  output  1  one-cycle pulse per output period, registered.
REQ-011 SHALL have port sync  input  1  phase-restart request; present only when CLKDIV_SYNC_EN is defined.

Function
REQ-012 SHALL hold internal counter cnt, WIDTH bits, and define N = div_active and H = N>>1.
REQ-013 SHALL, on an edge with cnt == N-1: set cnt to 0, clk_out to 1 and clk_en to 1.
REQ-014 SHALL, on every other edge: increment cnt by 1 and set clk_en to 0.
REQ-015 SHALL set clk_out to 0 on the edge with cnt == H-1.
REQ-016 SHALL keep clk_out unchanged on all edges not covered by REQ-013/REQ-015.
REQ-017 SHALL give clk_out a period of N clk cycles with H high and N-H low; even N gives exactly 50% duty.
REQ-018 SHALL, on div_load high, capture div_in into a pending register and set pending-valid.
REQ-019 SHALL substitute 2 for any captured value of 0 or 1.
REQ-020 SHALL keep only the most recent of repeated loads while pending-valid is set.
REQ-021 SHALL apply the pending ratio only on a wrap edge (REQ-013): div_active <= pending, pending-valid <= 0, div_ack <= 1 for one cycle.
REQ-022 SHALL treat div_load coincident with a wrap edge as pending: the old ratio runs one more full period and the new ratio applies at the following wrap.
REQ-023 SHALL run the ratio-update control as a two-state FSM: IDLE -> PENDING on div_load; PENDING -> IDLE on wrap edge; PENDING -> PENDING on div_load.
REQ-024 SHALL never output a truncated or stretched period; every period matches either the old ratio or the new one.

Reset
REQ-025 SHALL, while rst is high, force: cnt=0, clk_out=0, clk_en=0, div_ack=0, div_active=DEFAULT_DIV, pending-valid=0, FSM=IDLE.
REQ-026 SHALL produce the first clk_out rise and clk_en pulse on the Nth posedge after rst deasserts.
REQ-027 SHALL discard a pending ratio when rst asserts mid-operation.

Configuration
REQ-028 SHALL support macro CLKDIV_SYNC_EN.
REQ-029 SHALL, with CLKDIV_SYNC_EN defined: on an edge with sync high, behave as a wrap edge (cnt=0, clk_out=1, clk_en=1, pending ratio applied with div_ack) regardless of cnt; sync takes priority over REQ-013/REQ-015.
REQ-030 SHALL, with CLKDIV_SYNC_EN undefined: omit the sync port and provide no phase-restart path.

Verification
REQ-031 SHALL cover: reset release with DEFAULT_DIV=4 -> clk_en pulse every 4 cycles, first pulse on the 4th edge, clk_out 2 high / 2 low.
REQ-032 SHALL cover: div_in=5 with div_load mid-period -> current 4-period completes, then div_ack pulses once, div_active=5, clk_out 2 high / 3 low.
REQ-033 SHALL cover: div_in=0, then div_in=1 -> div_active=2 each time, clk_out toggles every cycle.
REQ-034 SHALL cover: loads of 6 and then 8 within one period -> only 8 applied, a single div_ack.
REQ-035 SHALL cover: rst asserted with a load pending at cnt=2 -> outputs clear immediately, div_active=DEFAULT_DIV, no div_ack.
REQ-036 SHALL cover: with CLKDIV_SYNC_EN, N=6, sync at cnt=3 -> next edge gives clk_out=1, clk_en=1, cnt=0, then a regular 6-cycle period.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider with a glitch-free ratio update applied only at period boundaries.
// Optional phase-restart input "sync" is enabled by defining CLKDIV_SYNC_EN.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic [WIDTH-1:0] div_active,
    output logic             clk_out,
    output logic             clk_en
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] captured;
    logic             wrap;
    logic             fall;
    logic             apply;

    assign half     = div_active >> 1;
    assign captured = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
    assign fall     = (cnt == half - WIDTH'(1));

`ifdef CLKDIV_SYNC_EN
    assign wrap = sync || (cnt == div_active - WIDTH'(1));
`else
    assign wrap = (cnt == div_active - WIDTH'(1));
`endif

    // A new ratio only lands on a wrap edge, so the period in flight is never cut short.
    assign apply = wrap && (state == PENDING);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (div_load) state_next = PENDING;
            PENDING: begin
                if (div_load)  state_next = PENDING;
                else if (wrap) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            clk_out    <= 1'b0;
            clk_en     <= 1'b0;
            div_ack    <= 1'b0;
            div_active <= WIDTH'(DEFAULT_DIV);
            pending    <= WIDTH'(DEFAULT_DIV);
        end else begin
            if (wrap) begin
                cnt     <= '0;
                clk_out <= 1'b1;
                clk_en  <= 1'b1;
            end else begin
                cnt    <= cnt + WIDTH'(1);
                clk_en <= 1'b0;
                if (fall) clk_out <= 1'b0;
            end
            div_ack <= apply;
            if (apply)    div_active <= pending;
            // A load on the wrap edge itself is held for the next boundary.
            if (div_load) pending    <= captured;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog: reset, ratio updates, clamping, reset-discard, load-on-wrap.
// The sync scenario is compiled in only when CLKDIV_SYNC_EN is defined.
module tb_clk_div_prog;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_ack;
    logic [WIDTH-1:0] div_active;
    logic             clk_out;
    logic             clk_en;
`ifdef CLKDIV_SYNC_EN
    logic             sync;
`endif

    int checks = 0;
    int errors = 0;

    clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CLKDIV_SYNC_EN
        .sync       (sync),
`endif
        .div_in     (div_in),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .div_active (div_active),
        .clk_out    (clk_out),
        .clk_en     (clk_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] exp_en;
        logic [15:0] exp_out;
        exp_en  = 16'b1000_1000;
        exp_out = 16'b1001_1000;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (clk_out !== 1'b0 || clk_en !== 1'b0 || div_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got out=%b en=%b ack=%b, want 0 0 0", clk_out, clk_en, div_ack);
        end
        checks++;
        if (div_active !== 8'd4) begin
            errors++;
            $display("[TB] FAIL reset_active: got %0d, want 4", div_active);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (clk_en !== exp_en[i] || clk_out !== exp_out[i] || div_ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_release edge %0d: got en=%b out=%b ack=%b, want %b %b 0",
                         i + 1, clk_en, clk_out, div_ack, exp_en[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_load5();
        logic [15:0] exp_en;
        logic [15:0] exp_out;
        logic [15:0] exp_ack;
        exp_en  = 16'b1_0000_1000;
        exp_out = 16'b1_0001_1001;
        exp_ack = 16'b0_0000_1000;
        div_in = 8'd5;
        for (int i = 0; i < 9; i++) begin
            div_load = (i == 0);
            step();
            checks++;
            if (clk_en !== exp_en[i] || clk_out !== exp_out[i] || div_ack !== exp_ack[i] ||
                div_active !== ((i < 3) ? 8'd4 : 8'd5)) begin
                errors++;
                $display("[TB] FAIL load5 edge %0d: got en=%b out=%b ack=%b act=%0d, want %b %b %b %0d",
                         i, clk_en, clk_out, div_ack, div_active, exp_en[i], exp_out[i], exp_ack[i],
                         (i < 3) ? 4 : 5);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_double_load();
        logic [15:0] exp_en;
        logic [15:0] exp_out;
        logic [15:0] exp_ack;
        int          acks;
        exp_en  = 16'b1_0000_0001_0000;
        exp_out = 16'b1_0000_1111_0001;
        exp_ack = 16'b0_0000_0001_0000;
        acks    = 0;
        for (int i = 0; i < 13; i++) begin
            div_load = (i == 0) || (i == 1);
            div_in   = (i == 0) ? 8'd6 : 8'd8;
            step();
            if (div_ack === 1'b1) acks++;
            checks++;
            if (clk_en !== exp_en[i] || clk_out !== exp_out[i] || div_ack !== exp_ack[i]) begin
                errors++;
                $display("[TB] FAIL double_load edge %0d: got en=%b out=%b ack=%b, want %b %b %b",
                         i, clk_en, clk_out, div_ack, exp_en[i], exp_out[i], exp_ack[i]);
            end
        end
        div_load = 1'b0;
        checks++;
        if (div_active !== 8'd8 || acks != 1) begin
            errors++;
            $display("[TB] FAIL double_load_result: got act=%0d acks=%0d, want 8 1", div_active, acks);
        end
    endtask

    task automatic test_clamp();
        logic [15:0] exp_en;
        logic [15:0] exp_out;
        logic [15:0] exp_ack;
        exp_en  = 16'b1010_1000_0000;
        exp_out = 16'b1010_1000_0111;
        exp_ack = 16'b0000_1000_0000;
        div_in = 8'd0;
        for (int i = 0; i < 12; i++) begin
            div_load = (i == 0);
            step();
            checks++;
            if (clk_en !== exp_en[i] || clk_out !== exp_out[i] || div_ack !== exp_ack[i]) begin
                errors++;
                $display("[TB] FAIL clamp0 edge %0d: got en=%b out=%b ack=%b, want %b %b %b",
                         i, clk_en, clk_out, div_ack, exp_en[i], exp_out[i], exp_ack[i]);
            end
        end
        checks++;
        if (div_active !== 8'd2) begin
            errors++;
            $display("[TB] FAIL clamp0_active: got %0d, want 2", div_active);
        end
        exp_en  = 16'b1010;
        exp_out = 16'b1010;
        exp_ack = 16'b0010;
        div_in = 8'd1;
        for (int i = 0; i < 4; i++) begin
            div_load = (i == 0);
            step();
            checks++;
            if (clk_en !== exp_en[i] || clk_out !== exp_out[i] || div_ack !== exp_ack[i] ||
                div_active !== 8'd2) begin
                errors++;
                $display("[TB] FAIL clamp1 edge %0d: got en=%b out=%b ack=%b act=%0d, want %b %b %b 2",
                         i, clk_en, clk_out, div_ack, div_active, exp_en[i], exp_out[i], exp_ack[i]);
            end
        end
        div_load = 1'b0;
    endtask

    task automatic test_reset_pending();
        int acks;
        acks = 0;
        // Switch to 7, then leave a load of 3 pending at cnt=2.
        div_in   = 8'd7;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        checks++;
        if (div_active !== 8'd7 || div_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set7: got act=%0d ack=%b, want 7 1", div_active, div_ack);
        end
        div_in   = 8'd3;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        checks++;
        if (clk_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_out: got %b, want 1", clk_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== 1'b0 || clk_en !== 1'b0 || div_ack !== 1'b0 || div_active !== 8'd4) begin
            errors++;
            $display("[TB] FAIL async_reset: got out=%b en=%b ack=%b act=%0d, want 0 0 0 4",
                     clk_out, clk_en, div_ack, div_active);
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (div_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || div_active !== 8'd4 || clk_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pending_discarded: got acks=%0d act=%0d en=%b, want 0 4 1",
                     acks, div_active, clk_en);
        end
    endtask

    task automatic test_load_on_wrap();
        logic [15:0] exp_en;
        logic [15:0] exp_out;
        logic [15:0] exp_ack;
        exp_en  = 16'b100_0001_0001;
        exp_out = 16'b100_0111_0011;
        exp_ack = 16'b000_0001_0000;
        for (int i = 0; i < 3; i++) step();
        div_in = 8'd6;
        for (int i = 0; i < 11; i++) begin
            div_load = (i == 0);
            step();
            checks++;
            if (clk_en !== exp_en[i] || clk_out !== exp_out[i] || div_ack !== exp_ack[i] ||
                div_active !== ((i < 4) ? 8'd4 : 8'd6)) begin
                errors++;
                $display("[TB] FAIL load_on_wrap edge %0d: got en=%b out=%b ack=%b act=%0d, want %b %b %b %0d",
                         i, clk_en, clk_out, div_ack, div_active, exp_en[i], exp_out[i], exp_ack[i],
                         (i < 4) ? 4 : 6);
            end
        end
        div_load = 1'b0;
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync();
        logic [15:0] exp_en;
        logic [15:0] exp_out;
        exp_en  = 16'b100_0001;
        exp_out = 16'b100_0111;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (clk_out !== 1'b0 || clk_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_sync: got out=%b en=%b, want 0 0", clk_out, clk_en);
        end
        for (int i = 0; i < 7; i++) begin
            sync = (i == 0);
            step();
            checks++;
            if (clk_en !== exp_en[i] || clk_out !== exp_out[i]) begin
                errors++;
                $display("[TB] FAIL sync edge %0d: got en=%b out=%b, want %b %b",
                         i, clk_en, clk_out, exp_en[i], exp_out[i]);
            end
        end
        sync = 1'b0;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        div_in   = '0;
        div_load = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sync     = 1'b0;
`endif
        test_reset();
        test_load5();
        test_double_load();
        test_clamp();
        test_reset_pending();
        test_load_on_wrap();
`ifdef CLKDIV_SYNC_EN
        test_sync();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
